// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with the Z/V/N flag register and a sticky halt.
// Squashes on flush, holds on stall, and bubbles forever after HLT retires.
module ex_mem_flag_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [WIDTH-1:0] ex_alu_result,
  input  logic             ex_ovfl,
  input  logic [3:0]       ex_rd,
  input  logic             ex_reg_wr,
  input  logic             ex_mem_rd,
  input  logic             ex_mem_wr,
  input  logic [WIDTH-1:0] ex_store_data,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_alu_result,
  output logic [3:0]       mem_rd,
  output logic             mem_reg_wr,
  output logic             mem_mem_rd,
  output logic             mem_mem_wr,
  output logic [WIDTH-1:0] mem_store_data,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             halted
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [3:0]       rd_q, rd_d;
  logic             reg_wr_q, reg_wr_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic [WIDTH-1:0] store_q, store_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic             halted_q, halted_d;

  logic result_zero;
  logic is_hlt;
  logic wr_gate;

  assign result_zero = ~|ex_alu_result;
  assign is_hlt      = (ex_opcode == OP_HLT);
  // HLT retires as a valid instruction but must not write anything.
  assign wr_gate     = ex_valid && !is_hlt;

  always_comb begin
    valid_d  = valid_q;
    alu_d    = alu_q;
    rd_d     = rd_q;
    reg_wr_d = reg_wr_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    store_d  = store_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    halted_d = halted_q;

    if (flush || (!stall && halted_q)) begin
      valid_d  = 1'b0;
      reg_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
    end else if (!stall) begin
      valid_d  = ex_valid;
      alu_d    = ex_alu_result;
      rd_d     = ex_rd;
      store_d  = ex_store_data;
      reg_wr_d = ex_reg_wr && wr_gate;
      mem_rd_d = ex_mem_rd && wr_gate;
      mem_wr_d = ex_mem_wr && wr_gate;

      if (ex_valid) begin
        unique case (ex_opcode)
          OP_ADD, OP_SUB: begin
            z_d = result_zero;
            n_d = ex_alu_result[WIDTH-1];
            v_d = ex_ovfl;
          end
          OP_XOR, OP_SLL, OP_SRA, OP_ROR: z_d = result_zero;
          OP_HLT:                         halted_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      rd_q     <= '0;
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      store_q  <= '0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      rd_q     <= rd_d;
      reg_wr_q <= reg_wr_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      store_q  <= store_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
      halted_q <= halted_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_result = alu_q;
  assign mem_rd         = rd_q;
  assign mem_reg_wr     = reg_wr_q;
  assign mem_mem_rd     = mem_rd_q;
  assign mem_mem_wr     = mem_wr_q;
  assign mem_store_data = store_q;
  assign flag_z         = z_q;
  assign flag_v         = v_q;
  assign flag_n         = n_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: a rule-level model checked every
// cycle, plus literal expectations taken from hand-worked vectors.
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_ovfl, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_alu_result, ex_store_data;
  logic        mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr;
  logic [15:0] mem_alu_result, mem_store_data;
  logic [3:0]  mem_rd;
  logic        flag_z, flag_v, flag_n, halted;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_mem_flag_stage #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result),
    .ex_ovfl(ex_ovfl), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_rd(mem_rd),
    .mem_reg_wr(mem_reg_wr), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
    .mem_store_data(mem_store_data), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .halted(halted)
  );

  // Model state: what the stage must hold after each edge.
  bit          live = 0;
  bit          e_valid, e_reg_wr, e_mem_rd, e_mem_wr, e_z, e_v, e_n, e_halt;
  logic [15:0] e_alu, e_store;
  logic [3:0]  e_rd;

  always @(posedge clk) begin
    if (rst) begin
      live = 1;
      {e_valid, e_reg_wr, e_mem_rd, e_mem_wr, e_z, e_v, e_n, e_halt} = '0;
      e_alu = 0; e_store = 0; e_rd = 0;
    end else if (live) begin
      if (flush) begin
        {e_valid, e_reg_wr, e_mem_rd, e_mem_wr} = '0;
      end else if (stall) begin
        // everything holds
      end else if (e_halt) begin
        {e_valid, e_reg_wr, e_mem_rd, e_mem_wr} = '0;
      end else begin
        e_valid  = ex_valid;
        e_alu    = ex_alu_result;
        e_store  = ex_store_data;
        e_rd     = ex_rd;
        e_reg_wr = ex_valid && ex_reg_wr && ex_opcode != 4'hF;
        e_mem_rd = ex_valid && ex_mem_rd && ex_opcode != 4'hF;
        e_mem_wr = ex_valid && ex_mem_wr && ex_opcode != 4'hF;
        if (ex_valid) begin
          if (ex_opcode <= 4'h1) begin
            e_z = (ex_alu_result == 16'h0);
            e_n = ex_alu_result[15];
            e_v = ex_ovfl;
          end else if (ex_opcode == 4'h2 || (ex_opcode >= 4'h4 && ex_opcode <= 4'h6)) begin
            e_z = (ex_alu_result == 16'h0);
          end else if (ex_opcode == 4'hF) begin
            e_halt = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%04h, required 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  // Data fields are only defined while the slot holds a valid instruction.
  always @(negedge clk) begin
    if (live) begin
      check("cyc.valid", {15'b0, mem_valid}, {15'b0, e_valid});
      check("cyc.ctl", {13'b0, mem_reg_wr, mem_mem_rd, mem_mem_wr},
            {13'b0, e_reg_wr, e_mem_rd, e_mem_wr});
      check("cyc.flags", {13'b0, flag_z, flag_v, flag_n}, {13'b0, e_z, e_v, e_n});
      check("cyc.halted", {15'b0, halted}, {15'b0, e_halt});
      if (e_valid) begin
        check("cyc.alu", mem_alu_result, e_alu);
        check("cyc.store", mem_store_data, e_store);
        check("cyc.rd", {12'b0, mem_rd}, {12'b0, e_rd});
      end
    end
  end

  task automatic step(input logic st, input logic fl, input logic v, input logic [3:0] op,
                      input logic [15:0] res, input logic ov, input logic [3:0] rd,
                      input logic rw, input logic mr, input logic mw, input logic [15:0] sd);
    @(negedge clk);
    stall = st; flush = fl; ex_valid = v; ex_opcode = op; ex_alu_result = res;
    ex_ovfl = ov; ex_rd = rd; ex_reg_wr = rw; ex_mem_rd = mr; ex_mem_wr = mw;
    ex_store_data = sd;
    @(posedge clk);
    #1;
    $display("[TB] t=%0t st=%0b fl=%0b v=%0b op=%h res=%04h -> valid=%0b alu=%04h zvn=%0b%0b%0b halt=%0b",
             $time, st, fl, v, op, res, mem_valid, mem_alu_result, flag_z, flag_v, flag_n, halted);
  endtask

  function automatic logic [15:0] zvn();
    return {13'b0, flag_z, flag_v, flag_n};
  endfunction

  initial begin
    rst = 1; stall = 0; flush = 0; ex_valid = 0; ex_opcode = 0; ex_alu_result = 0;
    ex_ovfl = 0; ex_rd = 0; ex_reg_wr = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_store_data = 0;

    step(0, 0, 1, 4'h0, 16'hFFFF, 1, 4'h7, 1, 1, 1, 16'h1234);
    step(0, 0, 1, 4'h0, 16'hFFFF, 1, 4'h7, 1, 1, 1, 16'h1234);
    check("rst.valid", {15'b0, mem_valid}, 16'h0);
    check("rst.flags", zvn(), 16'h0);
    check("rst.halted", {15'b0, halted}, 16'h0);
    check("rst.alu", mem_alu_result, 16'h0000);
    rst = 0;

    // PADDSB passes through, flags untouched
    step(0, 0, 1, 4'h7, 16'h7777, 1, 4'h3, 1, 0, 0, 16'h0);
    check("paddsb.alu", mem_alu_result, 16'h7777);
    check("paddsb.rd", {12'b0, mem_rd}, 16'h3);
    check("paddsb.reg_wr", {15'b0, mem_reg_wr}, 16'h1);
    check("paddsb.flags", zvn(), 16'h0);

    // flag sequence; zvn packs {Z,V,N}
    step(0, 0, 1, 4'h1, 16'h0000, 0, 4'h1, 1, 0, 0, 16'h0);
    check("sub0.flags", zvn(), 16'b100);
    step(0, 0, 1, 4'h2, 16'h8000, 1, 4'h1, 1, 0, 0, 16'h0);
    check("xor.flags", zvn(), 16'b000);
    step(0, 0, 1, 4'h0, 16'h8000, 1, 4'h1, 1, 0, 0, 16'h0);
    check("add.flags", zvn(), 16'b011);
    step(0, 0, 1, 4'h3, 16'h0000, 0, 4'h1, 1, 0, 0, 16'h0);
    check("red.flags", zvn(), 16'b011);
    step(0, 0, 1, 4'h4, 16'h0000, 0, 4'h2, 1, 0, 0, 16'h0);
    check("sll.flags", zvn(), 16'b111);
    step(0, 0, 1, 4'h7, 16'h0000, 0, 4'h2, 1, 0, 0, 16'h0);
    check("paddsb0.flags", zvn(), 16'b111);
    step(0, 0, 1, 4'h6, 16'h0001, 0, 4'h2, 1, 0, 0, 16'h0);
    check("ror.flags", zvn(), 16'b011);

    // stall holds LW while an ADD 0 waits in EX
    step(0, 0, 1, 4'h8, 16'h0040, 0, 4'h5, 1, 1, 0, 16'h0);
    check("lw.alu", mem_alu_result, 16'h0040);
    check("lw.mem_rd", {15'b0, mem_mem_rd}, 16'h1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 4'h0, 16'h0000, 0, 4'h6, 1, 0, 0, 16'h0);
      check("stall.alu", mem_alu_result, 16'h0040);
      check("stall.z", {15'b0, flag_z}, 16'h0);
    end
    step(0, 0, 1, 4'h0, 16'h0000, 0, 4'h6, 1, 0, 0, 16'h0);
    check("unstall.alu", mem_alu_result, 16'h0000);
    check("unstall.flags", zvn(), 16'b100);

    // flush wins over stall
    step(1, 1, 1, 4'h9, 16'h0010, 0, 4'h0, 0, 0, 1, 16'hBEEF);
    check("flush.valid", {15'b0, mem_valid}, 16'h0);
    check("flush.mem_wr", {15'b0, mem_mem_wr}, 16'h0);
    check("flush.flags", zvn(), 16'b100);

    // flush alongside a valid ADD: no flag update
    step(0, 1, 1, 4'h0, 16'h8001, 1, 4'h1, 1, 0, 0, 16'h0);
    check("flushadd.flags", zvn(), 16'b100);

    // invalid slot: no flags, no writes
    step(0, 0, 0, 4'h0, 16'h8000, 1, 4'h1, 1, 1, 1, 16'h0);
    check("bubble.valid", {15'b0, mem_valid}, 16'h0);
    check("bubble.flags", zvn(), 16'b100);

    // SW advances normally
    step(0, 0, 1, 4'h9, 16'h0020, 0, 4'h0, 0, 0, 1, 16'hCAFE);
    check("sw.store", mem_store_data, 16'hCAFE);
    check("sw.mem_wr", {15'b0, mem_mem_wr}, 16'h1);

    // halt
    step(0, 0, 1, 4'hF, 16'h0000, 1, 4'h4, 1, 1, 1, 16'h0);
    check("hlt.halted", {15'b0, halted}, 16'h1);
    check("hlt.valid", {15'b0, mem_valid}, 16'h1);
    check("hlt.ctl", {13'b0, mem_reg_wr, mem_mem_rd, mem_mem_wr}, 16'h0);
    step(0, 0, 1, 4'h0, 16'h1234, 1, 4'h4, 1, 0, 0, 16'h0);
    check("posthlt.valid", {15'b0, mem_valid}, 16'h0);
    check("posthlt.flags", zvn(), 16'b100);
    step(0, 0, 1, 4'h2, 16'h0005, 0, 4'h4, 1, 0, 0, 16'h0);
    check("posthlt2.z", {15'b0, flag_z}, 16'h1);

    rst = 1;
    step(1, 1, 1, 4'h0, 16'h0000, 0, 4'h0, 0, 0, 0, 16'h0);
    check("rst2.halted", {15'b0, halted}, 16'h0);
    check("rst2.flags", zvn(), 16'h0);
    rst = 0;
    step(0, 0, 1, 4'h0, 16'h0000, 0, 4'h1, 1, 0, 0, 16'h0);
    check("rearm.valid", {15'b0, mem_valid}, 16'h1);
    check("rearm.flags", zvn(), 16'b100);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_mem_flag_stage.md
# ex_mem_flag_stage

EX/MEM pipeline register with the architectural flag register (Z, V, N), directly downstream of the execute-stage ALU, including the 16-bit nibble-saturating PADDSB adder. Each cycle it captures the ALU result and the memory/writeback control of the instruction leaving EX. It updates flags according to the opcode, handles stall and flush, and latches a sticky halt when HLT retires through it.

## Interface

- WIDTH, 16, datapath width; only 16 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold every register this cycle.
- flush  in  1  load a bubble this cycle.
- ex_valid  in  1  EX holds a real instruction.
- ex_opcode  in  4  0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LW, 9 SW, A LLB, B LHB, C B, D BR, E PCS, F HLT.
- ex_alu_result  in  WIDTH  ALU output, including the PADDSB Sum.
- ex_ovfl  in  1  signed-overflow indication from the ADD/SUB path.
- ex_rd  in  4  destination register.
- ex_reg_wr  in  1  register-file write enable.
- ex_mem_rd / ex_mem_wr  in  1 each  load / store enables.
- ex_store_data  in  WIDTH  store data.
- mem_valid  out  1  registered copy of the valid bit.
- mem_alu_result, mem_rd, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_store_data  out  widths as above, registered copies.
- flag_z, flag_v, flag_n  out  1 each  architectural flags.
- halted  out  1  sticky; set once HLT retires through this stage.

## Operation

- Define `adv = !stall && !flush && !halted`.
- **Priority:** rst > flush > stall > normal. flush overrides stall so a mispredict squash is never lost.
- **rst:**
  - mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, halted and all flags go to 0.
  - mem_alu_result, mem_store_data and mem_rd go to 0.
- **flush (no rst):**
  - mem_valid, mem_reg_wr, mem_mem_rd and mem_mem_wr go to 0.
  - Data fields may hold their old values.
  - Flags and halted are unchanged.
- **stall (no rst, no flush):** every register, including the flags, holds its value.
- **Normal advance:**
  - All mem_* outputs load the ex_* values.
  - Control bits are gated: each of mem_reg_wr, mem_mem_rd and mem_mem_wr equals its ex_ control bit AND ex_valid.
- **Flag update**, only when adv && ex_valid:
  - ADD, SUB: Z = (ex_alu_result == 0); N = ex_alu_result[15]; V = ex_ovfl.
  - XOR, SLL, SRA, ROR: Z = (ex_alu_result == 0); N and V hold.
  - All other opcodes, including PADDSB, RED, LW and SW: no flag change.
- **Halt:**
  - On adv && ex_valid && opcode F, halted goes to 1.
  - From then on the stage inserts bubbles every cycle (mem_valid = 0) and freezes the flags until rst.
  - The HLT instruction itself passes through with mem_valid = 1 and all write enables 0.
- Arithmetic: no arithmetic is performed here; the zero test is a full 16-bit NOR.
- ex_ovfl is ignored for every opcode except 0 and 1.

## Timing

- One-cycle latency: the ex_* values present at edge k appear on mem_* after edge k.
- Flags reflect an instruction on the edge it enters MEM. A branch in EX during that same cycle sees the flags produced by the instruction now in MEM.
- stall asserted for N cycles: outputs are constant for N cycles, then advance on the first edge with stall low.
- rst during a stall or flush: the reset values win on that edge.
- Simultaneous flush and a valid ADD in EX: no flag update and mem_valid = 0.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan

- **Reset.** After rst held 2 cycles, release it. Required: mem_valid=0, flags=000, halted=0, mem_alu_result=0x0000.
- **PADDSB passthrough.** ex_valid=1, opcode 7, ex_alu_result=0x7777 (saturated 0x7777+0x1111), ex_rd=3, ex_reg_wr=1. Required next cycle: mem_alu_result=0x7777, mem_rd=3, mem_reg_wr=1, flags unchanged.
- **Flag sequence.**
  - SUB with result 0x0000, ex_ovfl=0: Z=1, N=0, V=0.
  - Then XOR with result 0x8000: Z=0, N stays 0.
  - Then ADD with result 0x8000, ex_ovfl=1: Z=0, N=1, V=1.
- **Stall.** Load LW (result 0x0040); hold stall for 3 cycles while EX shows ADD 0x0000. Required: outputs remain LW/0x0040 and Z does not change until stall drops.
- **Flush over stall.** stall=1 and flush=1 with a valid SW in EX. Required: mem_valid=0, mem_mem_wr=0, flags unchanged.
- **Halt.** Valid HLT enters. Required: halted=1 next cycle. A following valid ADD with result 0 produces mem_valid=0 and Z does not change; rst clears halted.
